arb_resp_router: RTL and testbench
==================================

// Module: arb_resp_router
// PURPOSE
// - Downstream companion of the round-robin arbitration tree: records the winning index of every
//   arbitrated request in an in-order ID FIFO and steers returning responses back to that requester.
// - Sits between the arbiter output (req/gnt/idx) and a shared in-order slave. It closes the
//   request/response loop for NumIn masters without per-master tagging in the slave.
// PARAMETERS
// - NumIn      default 4   number of masters; must equal arbiter NumIn; >= 1
// - DataWidth  default 32  response payload width
// - Depth      default 4   max outstanding requests (ID FIFO entries); >= 1
// - IdxWidth   derived     (NumIn > 1) ? clog2(NumIn) : 1; do not override
// - CntWidth   derived     clog2(Depth+1); do not override
// PORTS
// - clk_i        in   1                 clock, rising edge
// - rst_ni       in   1                 asynchronous reset, active low
// - flush_i      in   1                 synchronous clear of all outstanding state
// - arb_req_i    in   1                 arbiter output request valid (arbiter req_o)
// - arb_idx_i    in   IdxWidth          arbiter winning index (arbiter idx_o)
// - arb_gnt_o    out  1                 grant into arbiter (gnt_i); low throttles new requests
// - slv_gnt_i    in   1                 slave accepts the request forwarded alongside arbiter data
// - rsp_valid_i  in   1                 slave response valid
// - rsp_ready_o  out  1                 slave response ready
// - rsp_data_i   in   DataWidth         slave response payload
// - rsp_valid_o  out  NumIn             per-master response valid, one-hot0
// - rsp_ready_i  in   NumIn             per-master response ready
// - rsp_data_o   out  DataWidth         response payload, broadcast to all masters
// - outstanding_o out CntWidth          current FIFO occupancy
// - unexp_rsp_o  out  1                 sticky: response arrived with FIFO empty
// BEHAVIOUR
// - Reset/flush: wr_ptr, rd_ptr, count = 0; unexp_rsp_o = 0; hence rsp_valid_o = 0, rsp_ready_o = 0,
//   arb_gnt_o = slv_gnt_i (FIFO empty). flush_i has priority over all same-cycle events.
// - arb_gnt_o = slv_gnt_i & ~full (full: count == Depth). No combinational path from rsp_* to arb_gnt_o.
// - Push: arb_req_i & arb_gnt_o -> mem[wr_ptr] <= arb_idx_i, wr_ptr advances, wraps Depth-1 -> 0.
// - Head: when count != 0, head = mem[rd_ptr]; rsp_valid_o[head] = rsp_valid_i, others 0;
//   rsp_ready_o = rsp_ready_i[head]. rsp_data_o = rsp_data_i always (no register, 0-cycle latency).
// - Pop: rsp_valid_i & rsp_ready_o -> rd_ptr advances with wrap.
// - Empty: rsp_ready_o = 0, rsp_valid_o = 0. No bypass: a push and a response in the same cycle while
//   empty do not pair; response is delivered earliest the next cycle. If rsp_valid_i & empty,
//   unexp_rsp_o sets and holds until reset/flush.
// - Full: arb_gnt_o = 0 even if a pop occurs that cycle (no pop-to-push bypass); grant resumes next cycle.
// - Simultaneous push+pop, 0 < count < Depth: count unchanged, both pointers advance.
// - count: +1 on push only, -1 on pop only; never exceeds Depth nor underflows.
// - Depth == 1: pointers are constant 0; occupancy flag alone.
// - NumIn == 1: head forced to 0; storage of idx may be pruned.
// - Responses assumed in request order; slave reordering is out of scope.
// STRUCTURE
// - Shared package arb_pkg: idx width function, rsp_route_t {idx, valid} typedef, occupancy width fn.
// - One sub-module: arb_idx_fifo (circular IdxWidth x Depth storage, ptrs, count, full/empty);
//   top does handshake gating, one-hot decode of head and the sticky error flag.
// - Must lint clean under Verilator; only flops are FIFO storage, ptrs, count, unexp flag.
// TESTING
// - Reset: rst_ni low mid-traffic (count=3) -> next cycle outstanding_o=0, rsp_valid_o=0, unexp=0.
// - In-order routing NumIn=4, Depth=4: push idx 2,0,3 -> three responses D1,D2,D3 appear on
//   rsp_valid_o = 4'b0100, 4'b0001, 4'b1000 with rsp_data_o = D1,D2,D3 respectively.
// - Full: 4 pushes no responses -> arb_gnt_o=0 with slv_gnt_i=1; pop in cycle N -> arb_gnt_o=1 in N+1.
// - Backpressure: head idx 1, rsp_ready_i=4'b0000 for 5 cycles -> rsp_ready_o=0, count held at 1;
//   rsp_ready_i[1]=1 -> pop, outstanding_o 1 -> 0.
// - Wrap + simultaneous: 10 cycles of push+pop at count 2 -> count stays 2, idx order preserved across wrap.
// - Error/flush: rsp_valid_i=1 while empty -> unexp_rsp_o=1 next cycle, rsp_ready_o=0; flush_i=1
//   concurrent with push -> count=0, unexp_rsp_o=0 next cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the arbitration tree and its response router.
// - idx_width(): width of a requester index for a given number of masters.
// - cnt_width(): width of an occupancy counter that must represent 0..depth.
// - rsp_route_t: routing decision for the response at the head of the ID FIFO.
package arb_pkg;

  // Widest index the route struct can carry; leaves room for up to 256 masters.
  localparam int unsigned IdxMaxWidth = 8;

  function automatic int unsigned idx_width(input int unsigned num_in);
    return (num_in > 1) ? $clog2(num_in) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic [IdxMaxWidth-1:0] idx;    // requester that owns the head response
    logic                   valid;  // head entry exists (FIFO not empty)
  } rsp_route_t;

endpackage

// File: rtl/arb_idx_fifo.sv
// Circular in-order FIFO of winning requester indices.
// Ports:
// - clk_i, rst_ni : clock, asynchronous active-low reset
// - flush_i       : synchronous clear of pointers and occupancy (wins over push/pop)
// - push_i/idx_i  : write idx_i at the tail
// - pop_i         : retire the head entry
// - head_o        : index at the head (valid only when empty_o is low)
// - count_o       : current occupancy, full_o/empty_o derived from it
module arb_idx_fifo
  import arb_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned IdxWidth = 2,
  parameter int unsigned CntWidth = cnt_width(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [IdxWidth-1:0] idx_i,
  input  logic                pop_i,
  output logic [IdxWidth-1:0] head_o,
  output logic [CntWidth-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [IdxWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == CntWidth'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Guard here as well so occupancy can never overflow or underflow.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Explicit wrap keeps non-power-of-two depths correct; with Depth == 1
      // both pointers collapse to a constant 0.
      if (push_ok) wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= idx_i;
  end

endmodule

// File: rtl/arb_resp_router.sv
// Routes in-order slave responses back to the master that won arbitration.
// Ports:
// - clk_i, rst_ni, flush_i          : clock, async active-low reset, sync clear
// - arb_req_i/arb_idx_i/arb_gnt_o    : arbiter output handshake; every grant records idx
// - slv_gnt_i                        : slave accepts the forwarded request
// - rsp_valid_i/rsp_ready_o/rsp_data_i : shared slave response channel
// - rsp_valid_o/rsp_ready_i/rsp_data_o : per-master response channel (data broadcast)
// - outstanding_o                    : ID FIFO occupancy
// - unexp_rsp_o                      : sticky flag, response seen with nothing outstanding
module arb_resp_router
  import arb_pkg::*;
#(
  parameter int unsigned NumIn     = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 4,
  parameter int unsigned IdxWidth  = idx_width(NumIn),
  parameter int unsigned CntWidth  = cnt_width(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 arb_req_i,
  input  logic [IdxWidth-1:0]  arb_idx_i,
  output logic                 arb_gnt_o,
  input  logic                 slv_gnt_i,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [DataWidth-1:0] rsp_data_i,
  output logic [NumIn-1:0]     rsp_valid_o,
  input  logic [NumIn-1:0]     rsp_ready_i,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic [CntWidth-1:0]  outstanding_o,
  output logic                 unexp_rsp_o
);

  logic                fifo_full, fifo_empty;
  logic                push, pop;
  logic [IdxWidth-1:0] fifo_head;
  rsp_route_t          route;
  logic [NumIn-1:0]    head_onehot;
  logic                unexp_q, unexp_d;

  // Grant depends only on registered occupancy: a pop in the same cycle does
  // not reopen a full FIFO, which keeps rsp_* out of the grant path.
  assign arb_gnt_o = slv_gnt_i & ~fifo_full;
  assign push      = arb_req_i & arb_gnt_o;

  arb_idx_fifo #(
    .Depth    (Depth),
    .IdxWidth (IdxWidth),
    .CntWidth (CntWidth)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .idx_i   (arb_idx_i),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (outstanding_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    route       = '0;
    route.valid = ~fifo_empty;
    // A single master always owns the head.
    if (NumIn > 1) route.idx[IdxWidth-1:0] = fifo_head;
  end

  // One-hot0 decode of the head owner; all zero while the FIFO is empty,
  // so a response arriving with nothing outstanding is never accepted.
  for (genvar gi = 0; gi < NumIn; gi++) begin : g_decode
    assign head_onehot[gi] = route.valid & (route.idx == IdxMaxWidth'(gi));
  end

  assign rsp_valid_o = rsp_valid_i ? head_onehot : '0;
  assign rsp_ready_o = |(rsp_ready_i & head_onehot);
  assign rsp_data_o  = rsp_data_i;
  assign pop         = rsp_valid_i & rsp_ready_o;

  always_comb begin
    unexp_d = unexp_q;
    if (flush_i) unexp_d = 1'b0;
    else if (rsp_valid_i && fifo_empty) unexp_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) unexp_q <= 1'b0;
    else         unexp_q <= unexp_d;
  end

  assign unexp_rsp_o = unexp_q;

endmodule

// File: tb/tb_arb_resp_router.sv
module tb_arb_resp_router;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        arb_req_i;
  logic [1:0]  arb_idx_i;
  logic        arb_gnt_o;
  logic        slv_gnt_i;
  logic        rsp_valid_i;
  logic        rsp_ready_o;
  logic [31:0] rsp_data_i;
  logic [3:0]  rsp_valid_o;
  logic [3:0]  rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [2:0]  outstanding_o;
  logic        unexp_rsp_o;

  always #5 clk_i = ~clk_i;

  arb_resp_router #(
    .NumIn     (4),
    .DataWidth (32),
    .Depth     (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .arb_req_i     (arb_req_i),
    .arb_idx_i     (arb_idx_i),
    .arb_gnt_o     (arb_gnt_o),
    .slv_gnt_i     (slv_gnt_i),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_data_i    (rsp_data_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_data_o    (rsp_data_o),
    .outstanding_o (outstanding_o),
    .unexp_rsp_o   (unexp_rsp_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard of requester indices in grant order.
  logic [1:0] sb_idx [$];

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
    logic [3:0]  exp_oh;
  } route_vec_t;

  route_vec_t tv [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] v;
    v = 4'b0001 << i;
    return v;
  endfunction

  task automatic push_req(input logic [1:0] idx);
    arb_req_i = 1'b1;
    arb_idx_i = idx;
    slv_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("push_gnt", {63'd0, arb_gnt_o}, 64'd1);
    $display("push idx=%0d cnt=%0d", idx, outstanding_o);
    sb_idx.push_back(idx);
    step();
    arb_req_i = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] d);
    logic [1:0] e;
    rsp_valid_i = 1'b1;
    rsp_data_i  = d;
    rsp_ready_i = 4'b1111;
    @(negedge clk_i);
    if (sb_idx.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: got response with no expected entry");
    end else begin
      e = sb_idx.pop_front();
      chk("rsp_route", {60'd0, rsp_valid_o}, {60'd0, onehot(e)});
      chk("rsp_data", {32'd0, rsp_data_o}, {32'd0, d});
      chk("rsp_ready", {63'd0, rsp_ready_o}, 64'd1);
      $display("rsp data=%0h valid_o=%b exp_idx=%0d", d, rsp_valid_o, e);
    end
    step();
    rsp_valid_i = 1'b0;
    rsp_ready_i = 4'b0000;
  endtask

  initial begin
    logic [1:0] nidx;
    logic [1:0] e;

    tv[0] = '{idx: 2'd2, data: 32'hD1D1_0001, exp_oh: 4'b0100};
    tv[1] = '{idx: 2'd0, data: 32'hD2D2_0002, exp_oh: 4'b0001};
    tv[2] = '{idx: 2'd3, data: 32'hD3D3_0003, exp_oh: 4'b1000};

    rst_ni = 1'b0; flush_i = 1'b0; arb_req_i = 1'b0; arb_idx_i = 2'd0;
    slv_gnt_i = 1'b1; rsp_valid_i = 1'b0; rsp_data_i = '0; rsp_ready_i = '0;
    repeat (2) step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("reset_cnt", {61'd0, outstanding_o}, 64'd0);
    chk("reset_valid", {60'd0, rsp_valid_o}, 64'd0);
    chk("reset_ready", {63'd0, rsp_ready_o}, 64'd0);
    chk("reset_unexp", {63'd0, unexp_rsp_o}, 64'd0);
    chk("reset_gnt", {63'd0, arb_gnt_o}, 64'd1);
    step();

    // In-order routing from a table.
    for (int i = 0; i < 3; i++) push_req(tv[i].idx);
    @(negedge clk_i);
    chk("route_cnt", {61'd0, outstanding_o}, 64'd3);
    step();
    for (int i = 0; i < 3; i++) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = tv[i].data;
      rsp_ready_i = 4'b1111;
      @(negedge clk_i);
      chk("route_oh", {60'd0, rsp_valid_o}, {60'd0, tv[i].exp_oh});
      chk("route_data", {32'd0, rsp_data_o}, {32'd0, tv[i].data});
      e = sb_idx.pop_front();
      chk("route_sb", {60'd0, rsp_valid_o}, {60'd0, onehot(e)});
      $display("route vec=%0d valid_o=%b data=%0h", i, rsp_valid_o, rsp_data_o);
      step();
    end
    rsp_valid_i = 1'b0;
    rsp_ready_i = 4'b0000;
    @(negedge clk_i);
    chk("route_drained", {61'd0, outstanding_o}, 64'd0);
    step();

    // Reset mid-traffic with three outstanding.
    push_req(2'd1); push_req(2'd2); push_req(2'd3);
    rst_ni = 1'b0;
    rsp_valid_i = 1'b1;
    rsp_ready_i = 4'b1111;
    step();
    @(negedge clk_i);
    chk("rst_mid_cnt", {61'd0, outstanding_o}, 64'd0);
    chk("rst_mid_valid", {60'd0, rsp_valid_o}, 64'd0);
    chk("rst_mid_unexp", {63'd0, unexp_rsp_o}, 64'd0);
    $display("reset mid-traffic cnt=%0d", outstanding_o);
    step();
    rsp_valid_i = 1'b0;
    rsp_ready_i = 4'b0000;
    rst_ni = 1'b1;
    sb_idx.delete();
    step();

    // Full: grant drops, pop does not bypass, grant resumes next cycle.
    for (int i = 0; i < 4; i++) push_req(2'(i));
    arb_req_i = 1'b1; arb_idx_i = 2'd2;
    @(negedge clk_i);
    chk("full_gnt", {63'd0, arb_gnt_o}, 64'd0);
    chk("full_cnt", {61'd0, outstanding_o}, 64'd4);
    step();
    rsp_valid_i = 1'b1; rsp_data_i = 32'hF00D; rsp_ready_i = 4'b1111;
    @(negedge clk_i);
    chk("full_pop_gnt", {63'd0, arb_gnt_o}, 64'd0);
    e = sb_idx.pop_front();
    chk("full_pop_oh", {60'd0, rsp_valid_o}, {60'd0, onehot(e)});
    $display("full pop cycle gnt=%0b valid_o=%b", arb_gnt_o, rsp_valid_o);
    step();
    rsp_valid_i = 1'b0; rsp_ready_i = 4'b0000;
    @(negedge clk_i);
    chk("full_resume_gnt", {63'd0, arb_gnt_o}, 64'd1);
    chk("full_resume_cnt", {61'd0, outstanding_o}, 64'd3);
    sb_idx.push_back(2'd2);
    step();
    arb_req_i = 1'b0;
    for (int i = 0; i < 4; i++) rsp(32'h100 + 32'(i));
    @(negedge clk_i);
    chk("full_drained", {61'd0, outstanding_o}, 64'd0);
    step();

    // Backpressure on the head master.
    push_req(2'd1);
    rsp_valid_i = 1'b1; rsp_data_i = 32'hBEEF; rsp_ready_i = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("bp_ready", {63'd0, rsp_ready_o}, 64'd0);
      chk("bp_valid", {60'd0, rsp_valid_o}, 64'h2);
      chk("bp_cnt", {61'd0, outstanding_o}, 64'd1);
      $display("backpressure cycle=%0d cnt=%0d", i, outstanding_o);
      step();
    end
    rsp_ready_i = 4'b0010;
    @(negedge clk_i);
    chk("bp_release_ready", {63'd0, rsp_ready_o}, 64'd1);
    void'(sb_idx.pop_front());
    step();
    rsp_valid_i = 1'b0; rsp_ready_i = 4'b0000;
    @(negedge clk_i);
    chk("bp_release_cnt", {61'd0, outstanding_o}, 64'd0);
    step();

    // Wrap with simultaneous push and pop at occupancy 2.
    push_req(2'd3); push_req(2'd1);
    for (int i = 0; i < 10; i++) begin
      nidx = 2'($urandom_range(0, 3));
      arb_req_i = 1'b1; arb_idx_i = nidx; slv_gnt_i = 1'b1;
      rsp_valid_i = 1'b1; rsp_data_i = 32'hA000 + 32'(i); rsp_ready_i = 4'b1111;
      @(negedge clk_i);
      chk("wrap_cnt", {61'd0, outstanding_o}, 64'd2);
      chk("wrap_gnt", {63'd0, arb_gnt_o}, 64'd1);
      e = sb_idx.pop_front();
      chk("wrap_oh", {60'd0, rsp_valid_o}, {60'd0, onehot(e)});
      $display("wrap cycle=%0d push=%0d valid_o=%b", i, nidx, rsp_valid_o);
      sb_idx.push_back(nidx);
      step();
    end
    arb_req_i = 1'b0; rsp_valid_i = 1'b0; rsp_ready_i = 4'b0000;
    rsp(32'hC1); rsp(32'hC2);
    @(negedge clk_i);
    chk("wrap_drained", {61'd0, outstanding_o}, 64'd0);
    step();

    // Unexpected response while empty, no same-cycle bypass with a push.
    arb_req_i = 1'b1; arb_idx_i = 2'd2;
    rsp_valid_i = 1'b1; rsp_data_i = 32'hE1; rsp_ready_i = 4'b1111;
    @(negedge clk_i);
    chk("nobypass_ready", {63'd0, rsp_ready_o}, 64'd0);
    chk("nobypass_valid", {60'd0, rsp_valid_o}, 64'd0);
    chk("nobypass_unexp", {63'd0, unexp_rsp_o}, 64'd0);
    $display("empty response with push ready=%0b", rsp_ready_o);
    sb_idx.push_back(2'd2);
    step();
    arb_req_i = 1'b0;
    @(negedge clk_i);
    chk("unexp_set", {63'd0, unexp_rsp_o}, 64'd1);
    chk("late_cnt", {61'd0, outstanding_o}, 64'd1);
    e = sb_idx.pop_front();
    chk("late_oh", {60'd0, rsp_valid_o}, {60'd0, onehot(e)});
    chk("late_ready", {63'd0, rsp_ready_o}, 64'd1);
    step();
    rsp_valid_i = 1'b0; rsp_ready_i = 4'b0000;
    @(negedge clk_i);
    chk("unexp_sticky", {63'd0, unexp_rsp_o}, 64'd1);
    chk("late_drained", {61'd0, outstanding_o}, 64'd0);
    step();

    // Flush concurrent with a push clears everything.
    push_req(2'd0);
    arb_req_i = 1'b1; arb_idx_i = 2'd3; flush_i = 1'b1;
    step();
    arb_req_i = 1'b0; flush_i = 1'b0;
    sb_idx.delete();
    @(negedge clk_i);
    chk("flush_cnt", {61'd0, outstanding_o}, 64'd0);
    chk("flush_unexp", {63'd0, unexp_rsp_o}, 64'd0);
    chk("flush_valid", {60'd0, rsp_valid_o}, 64'd0);
    $display("flush cnt=%0d unexp=%0b", outstanding_o, unexp_rsp_o);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

endmodule
